// File: rtl/addr_seq_ctrl.sv
// addr_seq_ctrl: sequences VH/HV address generation and drains the address FIFO into the transposed weight memory.
// Optional generator watchdog is enabled with ADDR_SEQ_WDOG_EN.
module addr_seq_ctrl #(
  parameter int NUM_VN = 16,
  parameter int NUM_HN = 16,
  parameter int BW_ADDR = 5,
  parameter logic [2:0] CODE_IDLE = 3'd0,
  parameter logic [2:0] CODE_VH = 3'd1,
  parameter logic [2:0] CODE_HV = 3'd2,
  parameter int TIMEOUT = 64
) (
  input  logic               clk_f,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic               abort,
  output logic               ag_en,
  output logic [2:0]         ag_state,
  input  logic               gen_vh_finished,
  input  logic               gen_hv_finished,
  input  logic               empty_fifo,
  output logic               en_fetch,
  input  logic [BW_ADDR-1:0] addr_fetch,
  output logic               twm_valid,
  output logic [BW_ADDR-1:0] twm_addr,
  output logic               twm_phase,
  input  logic               twm_ready,
  output logic               busy,
  output logic               done,
  output logic [5:0]         vh_cnt,
  output logic [5:0]         hv_cnt,
  output logic               err
);
  typedef enum logic [2:0] {S_IDLE, S_GEN_VH, S_DRAIN_VH, S_GEN_HV, S_DRAIN_HV, S_DONE} state_t;
  if (NUM_VN < 1 || NUM_VN > 31 || NUM_HN < 1 || NUM_HN > 31 || TIMEOUT < 1) begin : g_bad_cfg
    $error("addr_seq_ctrl: neuron counts must be 1..31 and TIMEOUT positive");
  end
  state_t r_state, w_next;
  logic r_mode_hv, r_pend, r_valid, r_phase;
  logic [BW_ADDR-1:0] r_addr;
  logic [5:0] r_vh_cnt, r_hv_cnt;
  logic w_gen, w_drain, w_fin, w_drained, w_to, w_acc;
  assign w_gen = r_state == S_GEN_VH || r_state == S_GEN_HV;
  assign w_drain = r_state == S_DRAIN_VH || r_state == S_DRAIN_HV;
  assign w_fin = r_state == S_GEN_VH ? gen_vh_finished : gen_hv_finished;
  assign w_drained = empty_fifo && !r_pend && !r_valid;
  assign w_acc = r_valid && twm_ready && !abort;
`ifdef ADDR_SEQ_WDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] r_wdog;
  assign w_to = w_gen && !w_fin && r_wdog == WW'(TIMEOUT - 1);
  always_ff @(posedge clk_f)
    if (rst) r_wdog <= '0;
    else r_wdog <= (w_gen && w_next == r_state) ? r_wdog + 1'b1 : '0;
`else
  assign w_to = 1'b0;
`endif
  always_ff @(posedge clk_f)
    r_state <= rst ? S_IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start && mode != 2'b00) w_next = mode[0] ? S_GEN_VH : S_GEN_HV;
      S_GEN_VH:   w_next = w_fin ? S_DRAIN_VH : w_to ? S_IDLE : S_GEN_VH;
      S_DRAIN_VH: if (w_drained) w_next = r_mode_hv ? S_GEN_HV : S_DONE;
      S_GEN_HV:   w_next = w_fin ? S_DRAIN_HV : w_to ? S_IDLE : S_GEN_HV;
      S_DRAIN_HV: if (w_drained) w_next = S_DONE;
      default:    w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end
  always_comb begin
    ag_en = w_gen;
    ag_state = r_state == S_GEN_VH ? CODE_VH : r_state == S_GEN_HV ? CODE_HV : CODE_IDLE;
    busy = r_state != S_IDLE;
    done = r_state == S_DONE;
    en_fetch = w_drain && !empty_fifo && !r_pend && !r_valid && !abort;
    err = w_to && !abort;
  end
  // Counters clear on the edge entering their generate phase; abort suppresses any acceptance.
  always_ff @(posedge clk_f)
    if (rst) begin
      r_mode_hv <= 1'b0;
      r_pend <= 1'b0;
      r_valid <= 1'b0;
      r_phase <= 1'b0;
      r_addr <= '0;
      r_vh_cnt <= '0;
      r_hv_cnt <= '0;
    end else begin
      if (r_state == S_IDLE && w_next != S_IDLE) r_mode_hv <= mode[1];
      r_pend <= en_fetch;
      r_valid <= !abort && (r_pend || (r_valid && !twm_ready));
      if (r_pend) begin
        r_addr <= addr_fetch;
        r_phase <= r_state == S_DRAIN_HV;
      end
      r_vh_cnt <= (w_next == S_GEN_VH && r_state != S_GEN_VH) ? '0 :
                  (w_acc && !r_phase && r_vh_cnt != 6'd63) ? r_vh_cnt + 1'b1 : r_vh_cnt;
      r_hv_cnt <= (w_next == S_GEN_HV && r_state != S_GEN_HV) ? '0 :
                  (w_acc && r_phase && r_hv_cnt != 6'd63) ? r_hv_cnt + 1'b1 : r_hv_cnt;
    end
  assign twm_valid = r_valid;
  assign twm_addr = r_addr;
  assign twm_phase = r_phase;
  assign vh_cnt = r_vh_cnt;
  assign hv_cnt = r_hv_cnt;
endmodule

// File: doc/addr_seq_ctrl.md
ADDR_SEQ_CTRL -- requirements
Module: addr_seq_ctrl

Interface
REQ-001 The block SHALL have the following parameters:
- NUM_VN, 16, visible neurons per core (1..31).
- NUM_HN, 16, hidden neurons per core (1..31).
- BW_ADDR, 5, address width.
- CODE_IDLE, 3'd0, ag_state code meaning no generation.
- CODE_VH, 3'd1, ag_state code for the V->H phase.
- CODE_HV, 3'd2, ag_state code for the H->V phase.
- TIMEOUT, 64, watchdog limit in cycles (used only under ADDR_SEQ_WDOG_EN).

REQ-002 The block SHALL have the following ports:
- clk_f  in  1  clock
- rst  in  1  reset; synchronous, active-high; clock clk_f
- start  in  1  single-cycle start request
- mode  in  2  phase select: 01 VH only, 10 HV only, 11 VH then HV
- abort  in  1  single-cycle abort
- ag_en  out  1  address-generator enable
- ag_state  out  3  address-generator phase code
- gen_vh_finished  in  1  generator VH-phase done
- gen_hv_finished  in  1  generator HV-phase done
- empty_fifo  in  1  address FIFO empty
- en_fetch  out  1  single-cycle FIFO read strobe
- addr_fetch  in  BW_ADDR  FIFO read data
- twm_valid  out  1  address offered to the transposed weight memory
- twm_addr  out  BW_ADDR  offered address
- twm_phase  out  1  0 = VH, 1 = HV
- twm_ready  in  1  memory accepts the offered address
- busy  out  1  sequence in progress
- done  out  1  single-cycle completion pulse
- vh_cnt  out  6  addresses delivered in the last VH phase
- hv_cnt  out  6  addresses delivered in the last HV phase
- err  out  1  single-cycle watchdog error pulse

Function
REQ-003 The FSM SHALL have the states IDLE, GEN_VH, DRAIN_VH, GEN_HV, DRAIN_HV and DONE.
REQ-004 In IDLE, when start=1 and mode!=00, the FSM SHALL go to GEN_VH if mode[0]=1, else to GEN_HV; busy=1 from the next cycle.
REQ-005 start SHALL be ignored when mode=00 or when the FSM is not in IDLE.
REQ-006 In GEN_x the block SHALL drive ag_en=1 and ag_state=CODE_x; in all other states it SHALL drive ag_en=0 and ag_state=CODE_IDLE.
REQ-007 In GEN_x, when the matching gen_x_finished=1 is sampled, the FSM SHALL go to DRAIN_x on the next cycle. ag_en stays 1 in the sampling cycle so the generator counter wraps to 0.
REQ-008 In DRAIN_x, en_fetch SHALL be asserted for one cycle only when all of the following hold: empty_fifo=0, no read is pending, and twm_valid=0.
REQ-009 The FIFO read latency SHALL be 1 cycle. In the cycle after en_fetch, the block SHALL capture addr_fetch into twm_addr and set twm_valid=1 on the following edge.
REQ-010 twm_valid, twm_addr and twm_phase SHALL hold stable until twm_ready=1 is sampled with twm_valid=1. That cycle clears twm_valid and increments the phase counter (vh_cnt or hv_cnt).
REQ-011 A phase counter SHALL be cleared on entry to its GEN_x state and saturate at 63.
REQ-012 DRAIN_x SHALL exit when empty_fifo=1, no read is pending, twm_valid=0 and en_fetch=0.
- DRAIN_VH exits to GEN_HV if mode[1]=1, else to DONE.
- DRAIN_HV exits to DONE.
REQ-013 A phase with zero active neurons (FIFO empty throughout) SHALL pass through DRAIN_x with no fetch and leave its count at 0.
REQ-014 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE with busy=0. vh_cnt and hv_cnt hold until the next start.
REQ-015 abort=1 in any state SHALL, on the next edge:
- return the FSM to IDLE;
- clear twm_valid and the pending read;
- leave the counters unchanged;
- not assert done.
abort SHALL take priority over start, and the FIFO is not flushed by this block.
REQ-016 mode SHALL be latched at start; later changes to mode during the sequence SHALL have no effect.

Reset
REQ-017 rst=1 SHALL put the FSM in IDLE. All outputs SHALL be 0 (ag_state=CODE_IDLE), the counters and the pending flag cleared, and the watchdog counter cleared.
REQ-018 rst SHALL override abort and start, and assertion mid-sequence SHALL behave exactly as at power-up.

Configuration
REQ-019 With ADDR_SEQ_WDOG_EN defined, a counter SHALL run in each GEN_x state.
- If TIMEOUT cycles elapse without gen_x_finished, the FSM SHALL go to IDLE and pulse err for 1 cycle.
- Without the macro, err SHALL be tied to 0 and no watchdog logic SHALL exist.

Verification
REQ-020 mode=11, NUM_VN=NUM_HN=16, FIFO yields VH {2,5,9} then HV {0,15}, twm_ready=1 -> twm_addr sequence 2,5,9 (twm_phase=0) then 0,15 (twm_phase=1); vh_cnt=3, hv_cnt=2; one done pulse.
REQ-021 mode=01 with the FIFO always empty -> ag_en high until gen_vh_finished; no en_fetch; done asserted; vh_cnt=0.
REQ-022 twm_ready held 0 for 5 cycles with twm_valid=1 -> twm_addr stable; no second en_fetch; count increments only once ready=1.
REQ-023 abort during DRAIN_VH with twm_valid=1 -> IDLE next cycle; twm_valid=0; busy=0; no done.
REQ-024 start asserted while busy, or with mode=00 -> no state change.
REQ-025 With ADDR_SEQ_WDOG_EN defined and TIMEOUT=64, gen_vh_finished never asserted -> err pulse at cycle 64 of GEN_VH, then IDLE; without the macro the FSM stays in GEN_VH.
